dir_input_conditioner: RTL

//  Upstream front end of the game core. Takes the four raw, asynchronous,

---
 rtl/dir_input_conditioner.sv | 98 +++++++++
 1 files changed

// File: rtl/dir_input_conditioner.sv
// Direction-button front end: synchronizes and debounces four raw buttons,
// then issues each accepted press as a single one-cycle move, one direction per cycle.
module dir_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       R,
  input  logic       n_raw,
  input  logic       s_raw,
  input  logic       e_raw,
  input  logic       w_raw,
  input  logic       game_over,
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic [3:0] pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Lane order everywhere is {n,s,e,w}: bit 3 = north ... bit 0 = west.
  logic [3:0]             w_btn_raw;
  logic [SYNC_STAGES-1:0] r_sync   [4];
  logic [CNT_W-1:0]       r_cnt    [4];
  logic [3:0]             r_stable;
  logic [3:0]             w_synced;
  logic [3:0]             w_accept;
  logic [3:0]             w_rise;
  logic [3:0]             w_grant;
  logic [3:0]             r_pending;
  logic [3:0]             r_move;

  assign w_btn_raw = {n_raw, s_raw, e_raw, w_raw};

  always_comb begin
    w_synced = '0;
    w_accept = '0;
    for (int i = 0; i < 4; i++) begin
      w_synced[i] = r_sync[i][SYNC_STAGES-1];
      w_accept[i] = (w_synced[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  // Only a debounced 0->1 transition counts as a press; releases are silent.
  assign w_rise = w_accept & w_synced;

  always_ff @(posedge clock or negedge R) begin
    if (!R) begin
      r_stable <= '0;
      for (int i = 0; i < 4; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_btn_raw[i]};
        if (w_synced[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= w_synced[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Fixed priority N > S > E > W over the pending set.
  always_comb begin
    w_grant = '0;
    if (r_pending[3])      w_grant = 4'b1000;
    else if (r_pending[2]) w_grant = 4'b0100;
    else if (r_pending[1]) w_grant = 4'b0010;
    else if (r_pending[0]) w_grant = 4'b0001;
  end

  // A rise on the same edge its direction is granted re-arms pending, so it is not lost.
  always_ff @(posedge clock or negedge R) begin
    if (!R) begin
      r_pending <= '0;
      r_move    <= '0;
    end else if (game_over) begin
      r_pending <= '0;
      r_move    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_rise;
      r_move    <= w_grant;
    end
  end

  assign {n, s, e, w} = r_move;
  assign pending      = r_pending;

endmodule
